// File: rtl/binary_query_seq_pkg.sv
// rtl/binary_query_seq_pkg.sv - shared types and defaults for the binary query sequencer
//
// Purpose : FSM state encoding and the SEQ_LEN/ADDR_W/RD_LAT/OUT_W defaults shared
//           between the sequencer and the XOR/popcount datapath.
// Ports   : none (package).

package binary_query_seq_pkg;

    localparam int SEQ_LEN_DEF = 30;
    localparam int ADDR_W_DEF  = 5;
    localparam int RD_LAT_DEF  = 1;
    localparam int OUT_W_DEF   = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // States in which a datapath result belongs to the current query.
    function automatic logic is_capture_state(input state_e s);
        return (s == ST_CLEAR) || (s == ST_RUN) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/binary_query_seq_if.sv
// rtl/binary_query_seq_if.sv - control, operand-read, datapath and result-write bundle
//
// Purpose : groups the sequencer's handshake and buffer signals.
// Signals : start/abort/hold (controller -> seq), busy/done/err_ovf (seq -> controller),
//           rd_en/rd_addr (operand buffer), dp_clr/dp_valid/dp_out/dp_out_valid (datapath),
//           res_wr_en/res_wr_addr/res_wr_data (result buffer).
// Modports: master = sequencer side, slave = surrounding layer/datapath side.

interface binary_query_seq_if
    import binary_query_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int OUT_W  = OUT_W_DEF
);

    logic              start;
    logic              abort;
    logic              hold;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              dp_clr;
    logic              dp_valid;
    logic [OUT_W-1:0]  dp_out;
    logic              dp_out_valid;
    logic              res_wr_en;
    logic [ADDR_W-1:0] res_wr_addr;
    logic [OUT_W-1:0]  res_wr_data;
    logic              err_ovf;

    modport master (
        input  start, abort, hold, dp_out, dp_out_valid,
        output busy, done, rd_en, rd_addr, dp_clr, dp_valid,
               res_wr_en, res_wr_addr, res_wr_data, err_ovf
    );

    modport slave (
        output start, abort, hold, dp_out, dp_out_valid,
        input  busy, done, rd_en, rd_addr, dp_clr, dp_valid,
               res_wr_en, res_wr_addr, res_wr_data, err_ovf
    );

endinterface

// File: rtl/binary_query_seq_valid_pipe.sv
// rtl/binary_query_seq_valid_pipe.sv - DEPTH-stage valid shift register with sync clear
//
// Purpose : delays the operand read strobe by the buffer read latency so the datapath
//           valid lines up with the read data.
// Ports   : clk, rst_n (async, active-low), clr_i (sync clear of all stages),
//           d_i (strobe in), q_o (strobe delayed DEPTH cycles).

module binary_query_seq_valid_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] sh_q;

    if (DEPTH == 1) begin : g_one
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sh_q <= '0;
            end else if (clr_i) begin
                sh_q <= '0;
            end else begin
                sh_q <= d_i;
            end
        end
    end else begin : g_multi
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sh_q <= '0;
            end else if (clr_i) begin
                sh_q <= '0;
            end else begin
                sh_q <= {sh_q[DEPTH-2:0], d_i};
            end
        end
    end

    assign q_o = sh_q[DEPTH-1];

endmodule

// File: rtl/binary_query_seq.sv
// rtl/binary_query_seq.sv - query sequencer for the binary XOR/popcount aggregation datapath
//
// Purpose : on start clears the datapath accumulators, issues SEQ_LEN operand reads,
//           raises the datapath valid RD_LAT cycles after each read, and writes each
//           datapath result into the result buffer. Reports busy/done upward.
// Ports   : clk, rst_n (async, active-low)
//           bus (binary_query_seq_if.master):
//             start/abort/hold in, busy/done/err_ovf out,
//             rd_en/rd_addr out, dp_clr/dp_valid out, dp_out/dp_out_valid in,
//             res_wr_en/res_wr_addr/res_wr_data out.

module binary_query_seq
    import binary_query_seq_pkg::*;
#(
    parameter int SEQ_LEN = SEQ_LEN_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int RD_LAT  = RD_LAT_DEF,
    parameter int OUT_W   = OUT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    binary_query_seq_if.master bus
);

    // One extra bit so a full count (== SEQ_LEN) is distinguishable from any address.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SEQ_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SEQ_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic              res_wr_en_q, res_wr_en_d;
    logic [ADDR_W-1:0] res_wr_addr_q, res_wr_addr_d;
    logic [OUT_W-1:0]  res_wr_data_q, res_wr_data_d;
    logic              err_ovf_q, err_ovf_d;

    logic issue;
    logic capture;
    logic dp_valid;

    always_comb begin
        state_d       = state_q;
        issue_cnt_d   = issue_cnt_q;
        wr_cnt_d      = wr_cnt_q;
        res_wr_en_d   = 1'b0;
        res_wr_addr_d = res_wr_addr_q;
        res_wr_data_d = res_wr_data_q;
        err_ovf_d     = err_ovf_q;

        issue   = (state_q == ST_RUN) && !bus.hold;
        capture = bus.dp_out_valid && is_capture_state(state_q) && (wr_cnt_q != CNT_FULL);

        if (issue) begin
            issue_cnt_d = issue_cnt_q + CNT_ONE;
        end

        if (capture) begin
            res_wr_en_d   = 1'b1;
            res_wr_addr_d = wr_cnt_q[ADDR_W-1:0];
            res_wr_data_d = bus.dp_out;
            wr_cnt_d      = wr_cnt_q + CNT_ONE;
        end else if (bus.dp_out_valid) begin
            // A result with nowhere to go: outside a query or after the last slot.
            err_ovf_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d     = ST_CLEAR;
                    issue_cnt_d = '0;
                    wr_cnt_d    = '0;
                end
            end
            ST_CLEAR: state_d = ST_RUN;
            ST_RUN: begin
                if (issue && (issue_cnt_q == CNT_LAST)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // wr_cnt reaches FULL in the cycle the last write is on the bus.
                if (wr_cnt_q == CNT_FULL) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything, including a start in IDLE.
        if (bus.abort) begin
            state_d     = ST_IDLE;
            issue_cnt_d = '0;
            wr_cnt_d    = '0;
            res_wr_en_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            issue_cnt_q   <= '0;
            wr_cnt_q      <= '0;
            res_wr_en_q   <= 1'b0;
            res_wr_addr_q <= '0;
            res_wr_data_q <= '0;
            err_ovf_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            issue_cnt_q   <= issue_cnt_d;
            wr_cnt_q      <= wr_cnt_d;
            res_wr_en_q   <= res_wr_en_d;
            res_wr_addr_q <= res_wr_addr_d;
            res_wr_data_q <= res_wr_data_d;
            err_ovf_q     <= err_ovf_d;
        end
    end

    // The valid pipe only follows rd_en; hold never stalls it.
    binary_query_seq_valid_pipe #(
        .DEPTH (RD_LAT)
    ) u_valid_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (bus.abort),
        .d_i   (issue),
        .q_o   (dp_valid)
    );

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.dp_clr      = (state_q == ST_CLEAR);
    assign bus.rd_en       = issue;
    assign bus.rd_addr     = issue_cnt_q[ADDR_W-1:0];
    assign bus.dp_valid    = dp_valid;
    assign bus.res_wr_en   = res_wr_en_q;
    assign bus.res_wr_addr = res_wr_addr_q;
    assign bus.res_wr_data = res_wr_data_q;
    assign bus.err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_binary_query_seq.sv
// tb/tb_binary_query_seq.sv - directed bench for binary_query_seq (RD_LAT=1 and RD_LAT=3 in lockstep)

module tb_binary_query_seq;

    localparam int SEQ_LEN = 30;
    localparam int ADDR_W  = 5;
    localparam int OUT_W   = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic start = 1'b0, abort = 1'b0, hold = 1'b0, spur = 1'b0;

    int n_err = 0;
    int n_chk = 0;
    int lat [2] = '{1, 3};

    binary_query_seq_if #(.ADDR_W(ADDR_W), .OUT_W(OUT_W)) bus0 ();
    binary_query_seq_if #(.ADDR_W(ADDR_W), .OUT_W(OUT_W)) bus1 ();

    binary_query_seq #(.SEQ_LEN(SEQ_LEN), .ADDR_W(ADDR_W), .RD_LAT(1), .OUT_W(OUT_W))
        u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.master));
    binary_query_seq #(.SEQ_LEN(SEQ_LEN), .ADDR_W(ADDR_W), .RD_LAT(3), .OUT_W(OUT_W))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.master));

    assign bus0.start = start; assign bus0.abort = abort; assign bus0.hold = hold;
    assign bus1.start = start; assign bus1.abort = abort; assign bus1.hold = hold;

    logic [1:0] s_busy, s_done, s_rd_en, s_dp_clr, s_dv, s_wr_en, s_err;
    logic [ADDR_W-1:0] s_rd_addr [2];
    logic [ADDR_W-1:0] s_wr_addr [2];
    logic [OUT_W-1:0]  s_wr_data [2];
    assign s_busy   = {bus1.busy, bus0.busy};
    assign s_done   = {bus1.done, bus0.done};
    assign s_rd_en  = {bus1.rd_en, bus0.rd_en};
    assign s_dp_clr = {bus1.dp_clr, bus0.dp_clr};
    assign s_dv     = {bus1.dp_valid, bus0.dp_valid};
    assign s_wr_en  = {bus1.res_wr_en, bus0.res_wr_en};
    assign s_err    = {bus1.err_ovf, bus0.err_ovf};
    assign s_rd_addr[0] = bus0.rd_addr;     assign s_rd_addr[1] = bus1.rd_addr;
    assign s_wr_addr[0] = bus0.res_wr_addr; assign s_wr_addr[1] = bus1.res_wr_addr;
    assign s_wr_data[0] = bus0.res_wr_data; assign s_wr_data[1] = bus1.res_wr_data;

    function automatic logic [OUT_W-1:0] dp_fn(input int k);
        return 16'hA5C3 ^ 16'(k * 257);
    endfunction

    // Datapath model: latency 1, result k of a query is dp_fn(k).
    logic [1:0] dov;
    logic [OUT_W-1:0] dout [2];
    int seq [2];
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                dov[i]  <= 1'b0;
                seq[i]  <= 0;
                dout[i] <= '0;
            end else begin
                dov[i] <= s_dv[i] | spur;
                if (s_dp_clr[i]) seq[i] <= 0;
                else if (s_dv[i]) seq[i] <= seq[i] + 1;
                dout[i] <= dp_fn(seq[i]);
            end
        end
    end
    assign bus0.dp_out = dout[0]; assign bus0.dp_out_valid = dov[0];
    assign bus1.dp_out = dout[1]; assign bus1.dp_out_valid = dov[1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s[%0d] flags", tag, i),
                  32'({s_busy[i], s_done[i], s_rd_en[i], s_dp_clr[i], s_dv[i], s_wr_en[i], s_err[i]}), 32'd0);
            check($sformatf("%s[%0d] rd_addr", tag, i), 32'(s_rd_addr[i]), 32'd0);
            check($sformatf("%s[%0d] wr_addr", tag, i), 32'(s_wr_addr[i]), 32'd0);
            check($sformatf("%s[%0d] wr_data", tag, i), 32'(s_wr_data[i]), 32'd0);
        end
    endtask

    // Runs one query window of 64 cycles; c=0 is the cycle start is presented.
    task automatic run_query(input string tag, input int hold_at, input int abort_at,
                             input int st2, input int st3, input int exp_reads,
                             input int exp_dones, input int hold_len);
        int reads [2] = '{0, 0};
        int writes [2] = '{0, 0};
        int rd_errs [2] = '{0, 0};
        int wr_errs [2] = '{0, 0};
        int dones [2] = '{0, 0};
        int done_c [2] = '{-1, -1};
        int clr_n [2] = '{0, 0};
        int clr_c [2] = '{-1, -1};
        int first_rd [2] = '{-1, -1};
        int first_dv [2] = '{-1, -1};
        logic busy_after [2] = '{1'b1, 1'b1};
        logic [3:0] post_abort [2] = '{4'hF, 4'hF};
        int hold_errs = 0;
        int held = 0;
        int abort_c = -1;
        for (int c = 0; c < 64; c++) begin
            start = (c == 0) || (c == st2) || (c == st3);
            hold  = (hold_at >= 0) && (reads[0] == hold_at) && (held < 3);
            abort = (abort_at >= 0) && (abort_c < 0) && (reads[0] == abort_at);
            #1;
            if (abort) abort_c = c;
            if (hold) held++;
            for (int i = 0; i < 2; i++) begin
                if (hold && (s_rd_en[i] || s_rd_addr[i] != ADDR_W'(hold_at))) hold_errs++;
                if (s_rd_en[i]) begin
                    if (first_rd[i] < 0) first_rd[i] = c;
                    if (s_rd_addr[i] != ADDR_W'(reads[i])) rd_errs[i]++;
                    reads[i]++;
                end
                if (s_dv[i] && first_dv[i] < 0) first_dv[i] = c;
                if (s_wr_en[i]) begin
                    if (s_wr_addr[i] != ADDR_W'(writes[i]) || s_wr_data[i] != dp_fn(writes[i])) wr_errs[i]++;
                    writes[i]++;
                end
                if (done_c[i] >= 0 && c == done_c[i] + 1) busy_after[i] = s_busy[i];
                if (s_done[i]) begin dones[i]++; done_c[i] = c; end
                if (s_dp_clr[i]) begin clr_n[i]++; if (clr_c[i] < 0) clr_c[i] = c; end
                if (abort_c >= 0 && c == abort_c + 1)
                    post_abort[i] = {s_busy[i], s_rd_en[i], s_dv[i], s_wr_en[i]};
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0; hold = 1'b0; abort = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s[%0d] reads", tag, i), 32'(reads[i]), 32'(exp_reads));
            check($sformatf("%s[%0d] rd_addr_seq", tag, i), 32'(rd_errs[i]), 32'd0);
            check($sformatf("%s[%0d] wr_addr_data", tag, i), 32'(wr_errs[i]), 32'd0);
            check($sformatf("%s[%0d] dones", tag, i), 32'(dones[i]), 32'(exp_dones));
            check($sformatf("%s[%0d] clr_count", tag, i), 32'(clr_n[i]), 32'd1);
            check($sformatf("%s[%0d] clr_cycle", tag, i), 32'(clr_c[i]), 32'd1);
            check($sformatf("%s[%0d] first_rd", tag, i), 32'(first_rd[i]), 32'd2);
            check($sformatf("%s[%0d] first_dv", tag, i), 32'(first_dv[i]), 32'(2 + lat[i]));
            if (exp_dones > 0) begin
                check($sformatf("%s[%0d] writes", tag, i), 32'(writes[i]), 32'(SEQ_LEN));
                check($sformatf("%s[%0d] done_cycle", tag, i), 32'(done_c[i]),
                      32'(2 + SEQ_LEN + lat[i] + 2 + hold_len));
                check($sformatf("%s[%0d] busy_after_done", tag, i), 32'(busy_after[i]), 32'd0);
            end
            if (abort_at >= 0)
                check($sformatf("%s[%0d] post_abort", tag, i), 32'(post_abort[i]), 32'd0);
        end
        if (hold_at >= 0) begin
            check($sformatf("%s hold_cycles", tag), 32'(held), 32'd3);
            check($sformatf("%s hold_rd", tag), 32'(hold_errs), 32'd0);
        end
    endtask

    initial begin
        logic [1:0] wr_seen;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // start and abort together in IDLE: abort wins.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        #1;
        check("start_abort busy", 32'(s_busy), 32'd0);
        check("start_abort dp_clr", 32'(s_dp_clr), 32'd0);
        tick();

        run_query("nominal", -1, -1, -1, -1, SEQ_LEN, 1, 0);
        run_query("start_ignored", -1, -1, 20, 35, SEQ_LEN, 1, 0);
        run_query("hold", 10, -1, -1, -1, SEQ_LEN, 1, 3);
        run_query("abort", -1, 15, -1, -1, 16, 0, 0);
        run_query("after_abort", -1, -1, -1, -1, SEQ_LEN, 1, 0);

        // Asynchronous reset in the middle of RUN.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (12) tick();
        check("midrun busy", 32'(s_busy), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        run_query("rerun", -1, -1, -1, -1, SEQ_LEN, 1, 0);

        // Spurious datapath result in IDLE.
        check("err_before_spur", 32'(s_err), 32'd0);
        spur = 1'b1;
        tick();
        spur = 1'b0;
        wr_seen = s_wr_en;
        tick();
        wr_seen = wr_seen | s_wr_en;
        check("spur err_ovf", 32'(s_err), 32'd3);
        check("spur no_write", 32'(wr_seen), 32'd0);
        run_query("err_sticky", -1, -1, -1, -1, SEQ_LEN, 1, 0);
        check("sticky err_ovf", 32'(s_err), 32'd3);
        rst_n = 1'b0;
        #1;
        check("reset clears err_ovf", 32'(s_err), 32'd0);
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
